alu_ctrl_seq: RTL and testbench



---
 rtl/alu_ctrl_seq.sv | 165 ++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// Handshaked ALU control decoder with a latency counter for mul/div ops.
// Optional M-extension decode is enabled by defining ALUCTL_MEXT_EN.
module alu_ctrl_seq #(
  parameter int CTRL_W = 5,
  parameter int MD_LAT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [1:0]        i_alu_op,
  input  logic [6:0]        i_funct7,
  input  logic [2:0]        i_funct3,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [CTRL_W-1:0] o_alu_ctrl,
  output logic              o_multi_cycle,
  output logic              o_illegal,
  output logic              o_busy
);

  localparam int CNT_W = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;

  localparam logic [4:0] C_AND  = 5'b00000;
  localparam logic [4:0] C_OR   = 5'b00001;
  localparam logic [4:0] C_ADD  = 5'b00010;
  localparam logic [4:0] C_XOR  = 5'b00011;
  localparam logic [4:0] C_SLL  = 5'b00100;
  localparam logic [4:0] C_SRL  = 5'b00101;
  localparam logic [4:0] C_SUB  = 5'b00110;
  localparam logic [4:0] C_SRA  = 5'b00111;
  localparam logic [4:0] C_SLT  = 5'b01000;
  localparam logic [4:0] C_SLTU = 5'b01001;

  typedef enum logic [1:0] {IDLE, MD_WAIT, OUT} state_t;

  state_t             r_state, w_nextState;
  logic [CNT_W-1:0]   r_cnt;
  logic [CTRL_W-1:0]  r_aluCtrl;
  logic               r_multiCycle, r_illegal;
  logic [4:0]         w_decCtrl;
  logic               w_decMd, w_decIll, w_accept;

  always_comb begin
    w_decCtrl = C_ADD;
    w_decMd   = 1'b0;
    w_decIll  = 1'b0;
    case (i_alu_op)
      2'b00: w_decCtrl = C_ADD;
      2'b01: begin
        case (i_funct3)
          3'b000, 3'b001: w_decCtrl = C_SUB;
          3'b100, 3'b101: w_decCtrl = C_SLT;
          3'b110, 3'b111: w_decCtrl = C_SLTU;
          default:        w_decIll  = 1'b1;
        endcase
      end
      2'b10: begin
        if (i_funct7 == 7'b0000000) begin
          case (i_funct3)
            3'b000:  w_decCtrl = C_ADD;
            3'b001:  w_decCtrl = C_SLL;
            3'b010:  w_decCtrl = C_SLT;
            3'b011:  w_decCtrl = C_SLTU;
            3'b100:  w_decCtrl = C_XOR;
            3'b101:  w_decCtrl = C_SRL;
            3'b110:  w_decCtrl = C_OR;
            default: w_decCtrl = C_AND;
          endcase
        end else if (i_funct7 == 7'b0100000) begin
          case (i_funct3)
            3'b000:  w_decCtrl = C_SUB;
            3'b101:  w_decCtrl = C_SRA;
            default: w_decIll  = 1'b1;
          endcase
        end else if (i_funct7 == 7'b0000001) begin
`ifdef ALUCTL_MEXT_EN
          w_decCtrl = {2'b10, i_funct3};
          w_decMd   = 1'b1;
`else
          w_decIll  = 1'b1;
`endif
        end else begin
          w_decIll = 1'b1;
        end
      end
      default: begin
        case (i_funct3)
          3'b000:  w_decCtrl = C_ADD;
          3'b001:  begin
            if (i_funct7 == 7'b0000000) w_decCtrl = C_SLL;
            else                        w_decIll  = 1'b1;
          end
          3'b010:  w_decCtrl = C_SLT;
          3'b011:  w_decCtrl = C_SLTU;
          3'b100:  w_decCtrl = C_XOR;
          3'b101:  begin
            if (i_funct7 == 7'b0000000)      w_decCtrl = C_SRL;
            else if (i_funct7 == 7'b0100000) w_decCtrl = C_SRA;
            else                             w_decIll  = 1'b1;
          end
          3'b110:  w_decCtrl = C_OR;
          default: w_decCtrl = C_AND;
        endcase
      end
    endcase
    // Illegal encodings fall back to ADD as a harmless single-cycle op.
    if (w_decIll) begin
      w_decCtrl = C_ADD;
      w_decMd   = 1'b0;
    end
  end

  assign o_in_ready = !i_flush && ((r_state == IDLE) || ((r_state == OUT) && i_out_ready));
  assign w_accept   = i_in_valid && o_in_ready;

  always_comb begin
    w_nextState = r_state;
    if (i_flush) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_nextState = w_decMd ? MD_WAIT : OUT;
        MD_WAIT: if (r_cnt == '0) w_nextState = OUT;
        OUT: begin
          if (w_accept)         w_nextState = w_decMd ? MD_WAIT : OUT;
          else if (i_out_ready) w_nextState = IDLE;
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_aluCtrl    <= '0;
      r_multiCycle <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_aluCtrl    <= CTRL_W'(w_decCtrl);
        r_multiCycle <= w_decMd;
        r_illegal    <= w_decIll;
        if (w_decMd) r_cnt <= CNT_W'(MD_LAT - 2);
      end else if ((r_state == MD_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_out_valid   = (r_state == OUT);
  assign o_alu_ctrl    = r_aluCtrl;
  assign o_multi_cycle = r_multiCycle;
  assign o_illegal     = r_illegal;
`ifdef ALUCTL_MEXT_EN
  assign o_busy        = (r_state == MD_WAIT);
`else
  assign o_busy        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq; expectations follow ALUCTL_MEXT_EN when defined.
module tb_alu_ctrl_seq;

   localparam int MDLAT = 4;

   typedef struct packed {
      logic [4:0] ctrl;
      logic       mc;
      logic       ill;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic       inValid;
   logic       inReady;
   logic [1:0] aluOp;
   logic [6:0] funct7;
   logic [2:0] funct3;
   logic       outValid;
   logic       outReady;
   logic [4:0] aluCtrl;
   logic       multiCycle;
   logic       illegal;
   logic       busy;

   exp_t expQ[$];
   int   testsRun = 0;
   int   testsFailed = 0;

   alu_ctrl_seq #(.CTRL_W(5), .MD_LAT(MDLAT)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .i_flush(flush),
      .i_in_valid(inValid),
      .o_in_ready(inReady),
      .i_alu_op(aluOp),
      .i_funct7(funct7),
      .i_funct3(funct3),
      .o_out_valid(outValid),
      .i_out_ready(outReady),
      .o_alu_ctrl(aluCtrl),
      .o_multi_cycle(multiCycle),
      .o_illegal(illegal),
      .o_busy(busy)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Compares one observed value with its expected value and tallies the result.
   task automatic checkOutput(input string name, input int actual, input int expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Presents one request, waits (bounded) for in_ready and records its expected response.
   task automatic applyStimulus(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                                input logic [4:0] eCtrl, input logic eMc, input logic eIll);
      bit taken = 0;
      aluOp = op; funct7 = f7; funct3 = f3; inValid = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (inReady) begin
            expQ.push_back('{ctrl: eCtrl, mc: eMc, ill: eIll});
            taken = 1;
            break;
         end
      end
      if (!taken) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL acceptTimeout: got in_ready 0, expected 1 within 50 cycles");
      end
      @(posedge clk); #1;
      inValid = 1'b0;
   endtask

   // Monitor: every completed output handshake is compared against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && outValid && outReady) begin
         exp_t e;
         testsRun++;
         if (expQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL unexpectedOutput: got ctrl %b with no pending request, expected none", aluCtrl);
         end else begin
            e = expQ.pop_front();
            if ({aluCtrl, multiCycle, illegal} !== e) begin
               testsFailed++;
               $display("[TB] FAIL scoreboard: got ctrl %b mc %b ill %b, expected ctrl %b mc %b ill %b",
                        aluCtrl, multiCycle, illegal, e.ctrl, e.mc, e.ill);
            end
         end
      end
   end

   // Directed sequence: reset, decode vectors, back-to-back, stall, mul/div, reset and flush.
   initial begin
      exp_t tmp;
      rst_n = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
      aluOp = 2'b00; funct7 = 7'b0; funct3 = 3'b0;
      #1;
      checkOutput("resetOutValid", outValid, 0);
      checkOutput("resetCtrl", aluCtrl, 0);
      checkOutput("resetBusy", busy, 0);
      checkOutput("resetFlags", {multiCycle, illegal}, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("resetInReady", inReady, 1);
      @(posedge clk); #1;

      applyStimulus(2'b10, 7'b0100000, 3'b000, 5'b00110, 0, 0);
      @(negedge clk);
      checkOutput("subLatency", outValid, 1);
      @(posedge clk); #1;
      applyStimulus(2'b00, 7'b1111111, 3'b111, 5'b00010, 0, 0);
      applyStimulus(2'b01, 7'b0000000, 3'b110, 5'b01001, 0, 0);
      applyStimulus(2'b11, 7'b0100000, 3'b101, 5'b00111, 0, 0);
      applyStimulus(2'b11, 7'b0100000, 3'b001, 5'b00010, 0, 1);
      applyStimulus(2'b01, 7'b0000000, 3'b010, 5'b00010, 0, 1);
      applyStimulus(2'b10, 7'b0000000, 3'b111, 5'b00000, 0, 0);
      applyStimulus(2'b10, 7'b0000000, 3'b001, 5'b00100, 0, 0);
      applyStimulus(2'b10, 7'b0000011, 3'b000, 5'b00010, 0, 1);
      applyStimulus(2'b11, 7'b1010101, 3'b100, 5'b00011, 0, 0);
      @(posedge clk); #1;

      // Back-to-back: four R-type ops with no gap in out_valid.
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: begin funct7 = 7'b0000000; funct3 = 3'b100; tmp = '{5'b00011, 1'b0, 1'b0}; end
            1: begin funct7 = 7'b0000000; funct3 = 3'b110; tmp = '{5'b00001, 1'b0, 1'b0}; end
            2: begin funct7 = 7'b0000000; funct3 = 3'b010; tmp = '{5'b01000, 1'b0, 1'b0}; end
            default: begin funct7 = 7'b0100000; funct3 = 3'b101; tmp = '{5'b00111, 1'b0, 1'b0}; end
         endcase
         aluOp = 2'b10; inValid = 1'b1;
         @(negedge clk);
         checkOutput("b2bInReady", inReady, 1);
         if (i > 0) checkOutput("b2bNoBubble", outValid, 1);
         expQ.push_back(tmp);
         @(posedge clk); #1;
      end
      inValid = 1'b0;
      @(negedge clk);
      checkOutput("b2bLastValid", outValid, 1);
      @(negedge clk);
      checkOutput("b2bDrainIdle", outValid, 0);

      // Stall: output held while out_ready is low, competing request refused.
      @(posedge clk); #1;
      outReady = 1'b0;
      applyStimulus(2'b10, 7'b0000000, 3'b100, 5'b00011, 0, 0);
      aluOp = 2'b01; funct3 = 3'b000; inValid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput("stallValid", outValid, 1);
         checkOutput("stallInReady", inReady, 0);
         checkOutput("stallHeldCtrl", aluCtrl, 5'b00011);
      end
      @(posedge clk); #1;
      inValid = 1'b0; outReady = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;

      // Mul/div latency (DIVU).
`ifdef ALUCTL_MEXT_EN
      applyStimulus(2'b10, 7'b0000001, 3'b101, 5'b10101, 1, 0);
      for (int c = 1; c < MDLAT; c++) begin
         @(negedge clk);
         checkOutput("mdBusy", busy, 1);
         checkOutput("mdNoValid", outValid, 0);
         checkOutput("mdInReady", inReady, 0);
      end
      @(negedge clk);
      checkOutput("mdValidAtLat", outValid, 1);
      checkOutput("mdCtrl", aluCtrl, 5'b10101);
`else
      applyStimulus(2'b10, 7'b0000001, 3'b101, 5'b00010, 0, 1);
      @(negedge clk);
      checkOutput("mextOffValid", outValid, 1);
      checkOutput("mextOffIllegal", illegal, 1);
      checkOutput("mextOffBusy", busy, 0);
`endif
      @(posedge clk); #1;

      // Reset while an op is pending: nothing must come out for it.
`ifdef ALUCTL_MEXT_EN
      applyStimulus(2'b10, 7'b0000001, 3'b000, 5'b10000, 1, 0);
`else
      outReady = 1'b0;
      applyStimulus(2'b10, 7'b0000000, 3'b101, 5'b00101, 0, 0);
`endif
      rst_n = 1'b0;
      expQ.delete();
      #1;
      checkOutput("midResetValid", outValid, 0);
      checkOutput("midResetBusy", busy, 0);
      checkOutput("midResetCtrl", aluCtrl, 0);
      @(posedge clk); #1;
      rst_n = 1'b1; outReady = 1'b1;
      @(negedge clk);
      checkOutput("postResetInReady", inReady, 1);
      checkOutput("postResetValid", outValid, 0);
      @(posedge clk); #1;

      // Flush in IDLE together with in_valid: nothing accepted.
      flush = 1'b1; inValid = 1'b1; aluOp = 2'b00;
      @(negedge clk);
      checkOutput("flushIdleInReady", inReady, 0);
      @(posedge clk); #1;
      flush = 1'b0; inValid = 1'b0;
      @(negedge clk);
      checkOutput("flushIdleNoValid", outValid, 0);
      @(posedge clk); #1;

      // Flush a pending op (MD_WAIT with the macro, held OUT without).
`ifdef ALUCTL_MEXT_EN
      applyStimulus(2'b10, 7'b0000001, 3'b100, 5'b10100, 1, 0);
`else
      outReady = 1'b0;
      applyStimulus(2'b10, 7'b0000000, 3'b000, 5'b00010, 0, 0);
`endif
      void'(expQ.pop_back());
      flush = 1'b1; inValid = 1'b1; aluOp = 2'b00;
      @(negedge clk);
      checkOutput("flushPendInReady", inReady, 0);
      @(posedge clk); #1;
      flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
      @(negedge clk);
      checkOutput("flushPendValid", outValid, 0);
      checkOutput("flushPendBusy", busy, 0);
      checkOutput("flushPendInReady1", inReady, 1);
      repeat (MDLAT + 2) @(negedge clk);
      checkOutput("flushNoLateValid", outValid, 0);

      for (int n = 0; n < 20 && expQ.size() != 0; n++) @(negedge clk);
      checkOutput("sbDrained", expQ.size(), 0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
